// File: rtl/float_pkg.sv
// Shared float helpers for the IIR bank, adder and output converter.
// Field widths, bias, class encoding and unpack/classify functions.
package float_pkg;

    localparam int MAN_W   = 23;
    localparam int EXP_W   = 8;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic            sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        fp_class_e        cls;
    } fp_unpacked_t;

    function automatic fp_class_e fp_classify(
        input logic exp_zero,
        input logic exp_max,
        input logic man_zero
    );
        fp_class_e c;
        if (exp_zero) begin
            c = ZERO;
        end else if (exp_max) begin
            c = man_zero ? INF : NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

    // Mantissa comes back with the hidden bit restored (zero for e=0).
    function automatic fp_unpacked_t fp_unpack(input logic [MAN_W+EXP_W:0] f);
        fp_unpacked_t u;
        u.sign = f[MAN_W+EXP_W];
        u.exp  = f[MAN_W+EXP_W-1:MAN_W];
        u.man  = {|u.exp, f[MAN_W-1:0]};
        u.cls  = fp_classify(u.exp == '0, &u.exp, f[MAN_W-1:0] == '0);
        return u;
    endfunction

endpackage

// File: rtl/fp_round_shift.sv
// Bidirectional barrel shift of a float magnitude into an integer,
// round-half-to-even on right shifts, overflow flag past OUT_W bits.
module fp_round_shift
    import float_pkg::*;
#(
    parameter int MAN   = MAN_W,
    parameter int OUT_W = 24,
    parameter int SH_W  = EXP_W + 3
) (
    input  logic                   [MAN:0]     mag_i,
    input  logic signed            [SH_W-1:0]  sh_i,
    output logic                   [OUT_W-1:0] res_o,
    output logic                               ovf_o
);

    localparam int WW = MAN + 3 + OUT_W;
    localparam int RW = 2 * MAN + 3;

    int              shi;
    logic [WW-1:0]   lw;
    logic [RW-1:0]   rw;
    logic [MAN:0]    ip;
    logic            g;
    logic            s;
    logic            inc;
    logic [WW-1:0]   rnd;

    always_comb begin
        shi   = int'(sh_i);
        lw    = '0;
        rw    = '0;
        ip    = '0;
        g     = 1'b0;
        s     = 1'b0;
        inc   = 1'b0;
        rnd   = '0;
        res_o = '0;
        ovf_o = 1'b0;
        if (shi >= 0) begin
            // Any shift past OUT_W pushes the hidden 1 out of range.
            if (shi > OUT_W) begin
                ovf_o = 1'b1;
            end else begin
                lw    = WW'(mag_i) << shi;
                ovf_o = |lw[WW-1:OUT_W];
                res_o = lw[OUT_W-1:0];
            end
        end else if ((-shi) <= MAN + 2) begin
            rw    = {mag_i, {(MAN+2){1'b0}}} >> (-shi);
            ip    = rw[RW-1:MAN+2];
            g     = rw[MAN+1];
            s     = |rw[MAN:0];
            inc   = g & (s | ip[0]);
            rnd   = WW'(ip) + WW'(inc);
            ovf_o = |rnd[WW-1:OUT_W];
            res_o = rnd[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage float to saturated fixed-point converter with a
// valid/ready handshake, per-sample sat/NaN flags and a sticky summary.
module float_to_fixed_pipe
    import float_pkg::*;
#(
    parameter int MAN   = MAN_W,
    parameter int EXP   = EXP_W,
    parameter int OUT_W = 24,
    parameter int FRAC  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN+EXP:0]   in_float,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_fixed,
    output logic               out_sat,
    output logic               out_nan,
    input  logic               clr_sticky,
    output logic               sat_sticky
);

    localparam int BIAS_P = (1 << (EXP - 1)) - 1;
    localparam int SH_W   = EXP + 3;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic en;

    logic             v1_q, v1_d;
    logic             sign1_q, sign1_d;
    logic [EXP-1:0]   exp1_q, exp1_d;
    logic [MAN:0]     man1_q, man1_d;
    fp_class_e        cls1_q, cls1_d;

    logic             v2_q, v2_d;
    logic             sign2_q, sign2_d;
    logic [SH_W-1:0]  sh2_q, sh2_d;
    logic [MAN:0]     man2_q, man2_d;
    fp_class_e        cls2_q, cls2_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_fixed_q, out_fixed_d;
    logic             out_sat_q, out_sat_d;
    logic             out_nan_q, out_nan_d;
    logic             sticky_q, sticky_d;

    logic [EXP-1:0]   in_exp;
    logic [MAN-1:0]   in_man;
    int               sh_int;
    logic [OUT_W-1:0] mag;
    logic             ovf;

    assign en       = !out_valid_q | out_ready;
    assign in_ready = en & rst_n;
    assign in_exp   = in_float[MAN+EXP-1:MAN];
    assign in_man   = in_float[MAN-1:0];

    always_comb begin
        v1_d    = v1_q;
        sign1_d = sign1_q;
        exp1_d  = exp1_q;
        man1_d  = man1_q;
        cls1_d  = cls1_q;
        if (en) begin
            v1_d    = in_valid;
            sign1_d = in_float[MAN+EXP];
            exp1_d  = in_exp;
            man1_d  = {|in_exp, in_man};
            cls1_d  = fp_classify(in_exp == '0, &in_exp, in_man == '0);
        end
    end

    always_comb begin
        sh_int  = int'(exp1_q) - BIAS_P - MAN + FRAC;
        v2_d    = v2_q;
        sign2_d = sign2_q;
        sh2_d   = sh2_q;
        man2_d  = man2_q;
        cls2_d  = cls2_q;
        if (en) begin
            v2_d    = v1_q;
            sign2_d = sign1_q;
            sh2_d   = SH_W'(sh_int);
            man2_d  = man1_q;
            cls2_d  = cls1_q;
        end
    end

    fp_round_shift #(
        .MAN   (MAN),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) u_round_shift (
        .mag_i (man2_q),
        .sh_i  (sh2_q),
        .res_o (mag),
        .ovf_o (ovf)
    );

    // Rounding already happened on the magnitude; negate, then clip.
    always_comb begin
        out_valid_d = out_valid_q;
        out_fixed_d = out_fixed_q;
        out_sat_d   = out_sat_q;
        out_nan_d   = out_nan_q;
        if (en) begin
            out_valid_d = v2_q;
            out_fixed_d = '0;
            out_sat_d   = 1'b0;
            out_nan_d   = 1'b0;
            unique case (cls2_q)
                NAN: begin
                    out_nan_d = 1'b1;
                end
                INF: begin
                    out_sat_d   = 1'b1;
                    out_fixed_d = sign2_q ? MIN_NEG : MAX_POS;
                end
                NORM: begin
                    if (sign2_q) begin
                        if (ovf || (mag > MIN_NEG)) begin
                            out_sat_d   = 1'b1;
                            out_fixed_d = MIN_NEG;
                        end else begin
                            out_fixed_d = -mag;
                        end
                    end else begin
                        if (ovf || mag[OUT_W-1]) begin
                            out_sat_d   = 1'b1;
                            out_fixed_d = MAX_POS;
                        end else begin
                            out_fixed_d = mag;
                        end
                    end
                end
                default: begin
                    out_fixed_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        sticky_d = clr_sticky ? 1'b0 : sticky_q;
        if (out_valid_q && out_ready && (out_sat_q || out_nan_q)) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            exp1_q      <= '0;
            man1_q      <= '0;
            cls1_q      <= ZERO;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            sh2_q       <= '0;
            man2_q      <= '0;
            cls2_q      <= ZERO;
            out_valid_q <= 1'b0;
            out_fixed_q <= '0;
            out_sat_q   <= 1'b0;
            out_nan_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            sign1_q     <= sign1_d;
            exp1_q      <= exp1_d;
            man1_q      <= man1_d;
            cls1_q      <= cls1_d;
            v2_q        <= v2_d;
            sign2_q     <= sign2_d;
            sh2_q       <= sh2_d;
            man2_q      <= man2_d;
            cls2_q      <= cls2_d;
            out_valid_q <= out_valid_d;
            out_fixed_q <= out_fixed_d;
            out_sat_q   <= out_sat_d;
            out_nan_q   <= out_nan_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_fixed  = out_fixed_q;
    assign out_sat    = out_sat_q;
    assign out_nan    = out_nan_q;
    assign sat_sticky = sticky_q;

endmodule
